// File: rtl/rtype_encoder_pkg.sv
// Shared R-type encoding constants and the matching ALU-control decoder.
package rtype_encoder_pkg;

  localparam logic [3:0] ALUOP_AND = 4'b0000;
  localparam logic [3:0] ALUOP_OR  = 4'b0001;
  localparam logic [3:0] ALUOP_ADD = 4'b0010;
  localparam logic [3:0] ALUOP_SLL = 4'b0011;
  localparam logic [3:0] ALUOP_SUB = 4'b0100;
  localparam logic [3:0] ALUOP_SRL = 4'b0101;
  localparam logic [3:0] ALUOP_MUL = 4'b0110;
  localparam logic [3:0] ALUOP_XOR = 4'b0111;

  localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_MUL     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL     = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef struct packed {
    logic       legal;
    logic [2:0] funct3;
    logic [6:0] funct7;
  } enc_t;

  typedef struct packed {
    logic       legal;
    logic       regwrite;
    logic [3:0] aluop;
  } dec_t;

  // Inverse of the encode table; unknown opcode/funct pairs decode as illegal.
  function automatic dec_t decode_rtype(input logic [6:0] funct7,
                                        input logic [2:0] funct3,
                                        input logic [6:0] opcode);
    dec_t d;
    d = '0;
    if (opcode == OPCODE_RTYPE) begin
      d.legal = 1'b1;
      case ({funct7, funct3})
        {F7_BASE, F3_ADD_SUB}: d.aluop = ALUOP_ADD;
        {F7_SUB,  F3_ADD_SUB}: d.aluop = ALUOP_SUB;
        {F7_BASE, F3_OR}:      d.aluop = ALUOP_OR;
        {F7_BASE, F3_AND}:     d.aluop = ALUOP_AND;
        {F7_BASE, F3_SLL}:     d.aluop = ALUOP_SLL;
        {F7_BASE, F3_SRL}:     d.aluop = ALUOP_SRL;
        {F7_BASE, F3_MUL}:     d.aluop = ALUOP_MUL;
        {F7_BASE, F3_XOR}:     d.aluop = ALUOP_XOR;
        default:               d.legal = 1'b0;
      endcase
      d.regwrite = d.legal;
    end
    return d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Purpose: single-clock FIFO, DEPTH entries of WIDTH bits; rd_data is 0 when empty.
// Latency: a write is visible at rd_data the cycle after it is taken.
// Backpressure: writes ignored when full, reads ignored when empty; full is purely registered.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/rtype_encoder.sv
// Purpose: encode ALU-op requests into 32-bit R-type words, queued in an output FIFO.
// Latency: 1 cycle from acceptance to instr when the queue is empty.
// Backpressure: req_ready follows registered FIFO occupancy; a same-cycle pop never frees a full queue.
module rtype_encoder
  import rtype_encoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_aluop,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic        err_illegal,
  output logic [15:0] issued_cnt
);

  function automatic enc_t encode_aluop(input logic [3:0] op);
    enc_t e;
    e.legal  = 1'b1;
    e.funct3 = F3_ADD_SUB;
    e.funct7 = F7_BASE;
    case (op)
      ALUOP_ADD: e.funct3 = F3_ADD_SUB;
      ALUOP_SUB: e.funct7 = F7_SUB;
      ALUOP_OR:  e.funct3 = F3_OR;
      ALUOP_AND: e.funct3 = F3_AND;
      ALUOP_SLL: e.funct3 = F3_SLL;
      ALUOP_SRL: e.funct3 = F3_SRL;
      ALUOP_MUL: e.funct3 = F3_MUL;
      ALUOP_XOR: e.funct3 = F3_XOR;
      default:   e.legal  = 1'b0;
    endcase
    return e;
  endfunction

  enc_t        enc;
  logic        accept;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] word;
  logic        err_q;
  logic [15:0] cnt_q;

  assign enc    = encode_aluop(req_aluop);
  assign word   = {enc.funct7, req_rs2, req_rs1, enc.funct3, req_rd, OPCODE_RTYPE};

  // Ready is withheld during reset so requests presented then are dropped.
  assign req_ready   = !rst && !fifo_full;
  assign accept      = req_valid && req_ready;
  assign push        = accept && enc.legal;
  assign instr_valid = !fifo_empty;
  assign pop         = instr_valid && instr_ready;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (word),
    .rd_en   (pop),
    .rd_data (instr),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= accept && !enc.legal;
      if (pop) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign err_illegal = err_q;
  assign issued_cnt  = cnt_q;

endmodule

// File: doc/rtype_encoder.md
RTYPE_ENCODER -- requirements
Module: rtype_encoder

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the output FIFO entry count (power of two, 2..16).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  an ALU-op request is present.
REQ-005 req_ready  output  1  the block accepts a request this cycle.
REQ-006 req_aluop  input  4  ALU control code to encode.
REQ-007 req_rd, req_rs1, req_rs2  input  5 each  register indices.
REQ-008 instr_valid  output  1  instr holds an encoded word.
REQ-009 instr_ready  input  1  consumer takes instr this cycle.
REQ-010 instr  output  32  encoded R-type instruction word.
REQ-011 err_illegal  output  1  one-cycle pulse: an accepted request carried an unencodable aluop.
REQ-012 issued_cnt  output  16  count of words popped from the output, wraps.

Function
REQ-013 A request SHALL be accepted when req_valid && req_ready; an output word SHALL be popped when instr_valid && instr_ready.
REQ-014 Encoding SHALL be: opcode[6:0]=0110011, rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25].
REQ-015 aluop -> (funct3, funct7): 0010 ADD (000,0000000); 0100 SUB (000,0100000); 0001 OR (110,0000000); 0000 AND (111,0000000); 0011 SLL (001,0000000); 0101 SRL (101,0000000); 0110 MUL (010,0000000); 0111 XOR (100,0000000).
REQ-016 aluop 1000..1111 SHALL be illegal: the request is accepted, nothing is written to the FIFO, and err_illegal pulses high the following cycle.
REQ-017 A legal accepted request SHALL be written to the FIFO tail; the word SHALL be visible at instr no earlier than the cycle after acceptance (latency 1 when the FIFO was empty).
REQ-018 req_ready SHALL be high iff occupancy < DEPTH; a pop in the same cycle SHALL NOT make a full FIFO ready (no combinational ready-through-pop).
REQ-019 instr_valid SHALL be high iff occupancy > 0; instr SHALL show the head entry, and 32'h0 when empty.
REQ-020 Simultaneous push and pop with 0 < occupancy < DEPTH SHALL leave occupancy unchanged and preserve order.
REQ-021 instr SHALL remain stable while instr_valid && !instr_ready.
REQ-022 Read/write pointers SHALL wrap modulo DEPTH; occupancy SHALL range 0..DEPTH.
REQ-023 issued_cnt SHALL increment by 1 per pop and wrap 16'hFFFF -> 16'h0000.
REQ-024 Illegal requests SHALL NOT change occupancy or issued_cnt.

Reset
REQ-025 While rst is high at a clock edge: occupancy=0, pointers=0, issued_cnt=0, err_illegal=0, instr_valid=0, instr=0, req_ready=0.
REQ-026 req_ready SHALL go high the first cycle after rst deasserts; requests presented during reset SHALL be dropped.
REQ-027 Reset mid-operation SHALL discard all queued words without emitting them.

Structure
REQ-028 A shared package SHALL hold the aluop code constants (0000..0111), the R-type opcode 0110011, and the funct3/funct7 constants, used identically by the decoder side.
REQ-029 The encode table SHALL be a combinational function inside the block; the FIFO SHALL be one sub-module, sync_fifo (parameter DEPTH, WIDTH=32).

Verification
REQ-030 ADD: aluop=0010, rd=1, rs1=2, rs2=3 -> instr=32'h003100B3 one cycle later, instr_valid=1.
REQ-031 SUB: aluop=0100, rd=5, rs1=6, rs2=7 -> instr=32'h407302B3; feeding it to the ALU-control decoder returns 0100 with regwrite=1.
REQ-032 Full: 5 back-to-back legal requests, instr_ready=0 -> req_ready=0 after the 4th; 5th held; one pop -> req_ready=1 the next cycle, order preserved.
REQ-033 Illegal: aluop=1010 -> accepted, err_illegal pulses once, instr_valid stays 0, issued_cnt unchanged.
REQ-034 Streaming: continuous requests with instr_ready=1 -> one word per cycle, issued_cnt counts each; preload 16'hFFFF wraps to 0.
REQ-035 Reset with 3 queued words -> instr_valid=0 and issued_cnt=0 the cycle after; none of the 3 words appear.
